// File: rtl/mem_fetch_if.sv
// mem_fetch_if: sequences one fetch/load/store at a time onto a fixed-latency single-port SRAM.
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o         request handshake; accepted when both are high at a clk edge
//   req_ifetch_i, req_write_i       request kind: fetch, store, or load (neither set)
//   req_addr_i, req_wdata_i         byte address and store data
//   resp_valid_o, resp_err_o        one-cycle completion pulse and error flag
//   ir_o, old_pc_o, mdr_o           instruction register, last fetch address, memory data register
//   op_o, func3_o, func7_o          instruction fields decoded from ir_o
//   mem_en_o, mem_we_o, mem_addr_o  registered SRAM strobes and word address
//   mem_wdata_o, mem_rdata_i        SRAM write and read data
module mem_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WORD_AW = 10,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  input  logic               req_ifetch_i,
  input  logic               req_write_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [DATA_W-1:0]  req_wdata_i,
  output logic               req_ready_o,
  output logic               resp_valid_o,
  output logic               resp_err_o,
  output logic [DATA_W-1:0]  ir_o,
  output logic [ADDR_W-1:0]  old_pc_o,
  output logic [DATA_W-1:0]  mdr_o,
  output logic [6:0]         op_o,
  output logic [2:0]         func3_o,
  output logic [6:0]         func7_o,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic [WORD_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic [DATA_W-1:0]  mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_e;
  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ifetch_q, ifetch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              bad;
  // misaligned, contradictory kind, or beyond the SRAM word range
  assign bad = (|req_addr_i[1:0]) | (req_ifetch_i & req_write_i) | (|req_addr_i[ADDR_W-1:WORD_AW+2]);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ifetch_d = ifetch_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    ir_d     = ir_q;
    pc_d     = pc_q;
    mdr_d    = mdr_q;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        ifetch_d = req_ifetch_i;
        addr_d   = req_addr_i;
        wdata_d  = req_wdata_i;
        state_d  = bad ? ERR : ISSUE;
        en_d     = !bad;
        we_d     = !bad & req_write_i;
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        cnt_d   = 3'(MEM_LAT - 1);
      end
      WAIT: if (cnt_q == 3'd0) begin
        state_d = DONE;
        ir_d    = ifetch_q ? mem_rdata_i : ir_q;
        pc_d    = ifetch_q ? addr_q : pc_q;
        mdr_d   = ifetch_q ? mdr_q : mem_rdata_i;
      end else cnt_d = cnt_q - 3'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ifetch_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      ir_q     <= DATA_W'(32'h0000_0013);
      pc_q     <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ifetch_q <= ifetch_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      en_q     <= en_d;
      we_q     <= we_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      mdr_q    <= mdr_d;
    end
  end
  assign req_ready_o  = state_q == IDLE;
  assign resp_valid_o = (state_q == DONE) | (state_q == ERR);
  assign resp_err_o   = state_q == ERR;
  assign ir_o         = ir_q;
  assign old_pc_o     = pc_q;
  assign mdr_o        = mdr_q;
  assign op_o         = ir_q[6:0];
  assign func3_o      = ir_q[14:12];
  assign func7_o      = ir_q[31:25];
  assign mem_en_o     = en_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q[WORD_AW+1:2];
  assign mem_wdata_o  = wdata_q;
endmodule

// File: tb/tb_mem_fetch_if.sv
// tb_mem_fetch_if: directed bench driving three mem_fetch_if instances (MEM_LAT 2, 1, 7) with SRAM models.
module tb_mem_fetch_if;
  logic clk = 1'b0;
  logic rst_n;
  logic f_i, w_i;
  logic [31:0] a_i, d_i;
  logic rv [3];
  logic rdy [3], resv [3], rerr [3], en [3], we [3];
  logic [31:0] ir [3], pc [3], mdr [3], wd [3], rd [3];
  logic [9:0] ma [3];
  logic [6:0] op [3], f7 [3];
  logic [2:0] f3 [3];
  int nvec = 0, nerr = 0;
  int lat, en_cnt, we_cnt, rhi;
  logic [9:0] ea;
  logic got_err;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    logic [31:0] mem [0:1023];
    logic [1023:0] wv;
    logic [31:0] pipe [0:7];
    always @(posedge clk) begin
      if (!rst_n) wv <= '0;
      else if (en[g] && we[g]) begin
        mem[ma[g]] <= wd[g];
        wv[ma[g]] <= 1'b1;
      end
      pipe[0] <= (en[g] && !we[g]) ? (wv[ma[g]] ? mem[ma[g]] : (ma[g] == 10'd4 ? 32'h0050_0093 : 32'h1000_0000 | 32'(ma[g]))) : 32'hBAD0_BAD0;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign rd[g] = pipe[L-1];
    mem_fetch_if #(.MEM_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(rv[g]), .req_ifetch_i(f_i), .req_write_i(w_i),
      .req_addr_i(a_i), .req_wdata_i(d_i),
      .req_ready_o(rdy[g]), .resp_valid_o(resv[g]), .resp_err_o(rerr[g]),
      .ir_o(ir[g]), .old_pc_o(pc[g]), .mdr_o(mdr[g]),
      .op_o(op[g]), .func3_o(f3[g]), .func7_o(f7[g]),
      .mem_en_o(en[g]), .mem_we_o(we[g]), .mem_addr_o(ma[g]),
      .mem_wdata_o(wd[g]), .mem_rdata_i(rd[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn(input int k, input logic f, input logic w, input logic [31:0] a, input logic [31:0] d);
    chk("ready_before", 32'(rdy[k]), 32'd1);
    f_i = f; w_i = w; a_i = a; d_i = d; rv[k] = 1'b1;
    @(posedge clk); #1;
    rv[k] = 1'b0; f_i = 1'b0; w_i = 1'b0; a_i = 32'hFFFF_FFFF; d_i = 32'h5555_5555;
    lat = 0; en_cnt = 0; we_cnt = 0; rhi = 0; ea = '0;
    while (1) begin
      if (en[k]) begin en_cnt++; ea = ma[k]; end
      if (we[k]) we_cnt++;
      if (rdy[k]) rhi++;
      if (resv[k] || lat >= 20) break;
      @(posedge clk); #1;
      lat++;
    end
    got_err = rerr[k];
    chk("ready_low_in_txn", 32'(rhi), 32'd0);
    @(posedge clk); #1;
    chk("resp_one_cycle", 32'(resv[k]), 32'd0);
    chk("ready_after", 32'(rdy[k]), 32'd1);
  endtask
  initial begin
    int bad;
    rst_n = 1'b0; f_i = 1'b0; w_i = 1'b0; a_i = '0; d_i = '0;
    rv[0] = 1'b0; rv[1] = 1'b0; rv[2] = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ir", ir[0], 32'h0000_0013);
    chk("rst_op", 32'(op[0]), 32'h13);
    chk("rst_en", 32'(en[0]), 32'd0);
    chk("rst_mdr", mdr[0], 32'd0);
    chk("rst_pc", pc[0], 32'd0);
    chk("rst_resp", 32'(resv[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    // async reset while mem_en is high
    f_i = 1'b1; a_i = 32'h10; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("issue_en", 32'(en[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1 chk("async_en", 32'(en[0]), 32'd0);
    chk("async_ready", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    repeat (6) begin @(posedge clk); #1; if (resv[0] || ir[0] !== 32'h13) bad++; end
    chk("no_resp_after_rst", 32'(bad), 32'd0);
    // fetch
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("fetch_lat", 32'(lat), 32'd3);
    chk("fetch_en_cnt", 32'(en_cnt), 32'd1);
    chk("fetch_addr", 32'(ea), 32'd4);
    chk("fetch_we", 32'(we_cnt), 32'd0);
    chk("fetch_err", 32'(got_err), 32'd0);
    chk("fetch_ir", ir[0], 32'h0050_0093);
    chk("fetch_pc", pc[0], 32'h10);
    chk("fetch_op", 32'(op[0]), 32'h13);
    chk("fetch_f3", 32'(f3[0]), 32'd0);
    chk("fetch_f7", 32'(f7[0]), 32'd0);
    // store then load
    txn(0, 1'b0, 1'b1, 32'h24, 32'hDEAD_BEEF);
    chk("st_lat", 32'(lat), 32'd1);
    chk("st_en_cnt", 32'(en_cnt), 32'd1);
    chk("st_we_cnt", 32'(we_cnt), 32'd1);
    chk("st_addr", 32'(ea), 32'd9);
    chk("st_ir", ir[0], 32'h0050_0093);
    txn(0, 1'b0, 1'b0, 32'h24, 32'h0);
    chk("ld_lat", 32'(lat), 32'd3);
    chk("ld_we_cnt", 32'(we_cnt), 32'd0);
    chk("ld_mdr", mdr[0], 32'hDEAD_BEEF);
    chk("ld_ir", ir[0], 32'h0050_0093);
    chk("ld_pc", pc[0], 32'h10);
    txn(0, 1'b0, 1'b0, 32'h30, 32'h0);
    chk("ld2_mdr", mdr[0], 32'h1000_000C);
    // rejected requests
    txn(0, 1'b0, 1'b0, 32'h22, 32'h0);
    chk("e1_lat", 32'(lat), 32'd0);
    chk("e1_err", 32'(got_err), 32'd1);
    chk("e1_en", 32'(en_cnt), 32'd0);
    txn(0, 1'b1, 1'b1, 32'h20, 32'h0);
    chk("e2_lat", 32'(lat), 32'd0);
    chk("e2_err", 32'(got_err), 32'd1);
    chk("e2_en", 32'(en_cnt), 32'd0);
    txn(0, 1'b0, 1'b0, 32'h1000, 32'h0);
    chk("e3_lat", 32'(lat), 32'd0);
    chk("e3_err", 32'(got_err), 32'd1);
    chk("e3_en", 32'(en_cnt), 32'd0);
    chk("err_mdr", mdr[0], 32'h1000_000C);
    chk("err_ir", ir[0], 32'h0050_0093);
    chk("err_pc", pc[0], 32'h10);
    // reset during WAIT
    f_i = 1'b1; a_i = 32'h40; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("midrd_ir", ir[0], 32'h13);
    chk("midrd_pc", pc[0], 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    repeat (10) begin @(posedge clk); #1; if (resv[0] || ir[0] !== 32'h13) bad++; end
    chk("midrd_quiet", 32'(bad), 32'd0);
    txn(0, 1'b1, 1'b0, 32'h44, 32'h0);
    chk("refetch_lat", 32'(lat), 32'd3);
    chk("refetch_ir", ir[0], 32'h1000_0011);
    chk("refetch_pc", pc[0], 32'h44);
    // other latencies, back-to-back fetches
    for (int k = 1; k < 3; k++) begin
      txn(k, 1'b1, 1'b0, 32'h8, 32'h0);
      chk("lat_a", 32'(lat), (k == 1) ? 32'd2 : 32'd8);
      chk("lat_a_ir", ir[k], 32'h1000_0002);
      txn(k, 1'b1, 1'b0, 32'hC, 32'h0);
      chk("lat_b", 32'(lat), (k == 1) ? 32'd2 : 32'd8);
      chk("lat_b_ir", ir[k], 32'h1000_0003);
      chk("lat_b_pc", pc[k], 32'hC);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
